// File: rtl/bram_rd_pkg.sv
// bram_rd_pkg: shared latency and credit-width helpers for the BRAM read server.
package bram_rd_pkg;

    function automatic int bram_lat(input int pipelined);
        return (pipelined != 0) ? 2 : 1;
    endfunction

    function automatic int credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/bram_read_server_resp_fifo.sv
// resp_fifo: first-word-fall-through response FIFO with registered head and valid.
module resp_fifo
    import bram_rd_pkg::*;
#(
    parameter  int WIDTH = 1,
    parameter  int DEPTH = 4,
    localparam int CW    = credit_w(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);
    localparam int            AW   = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CW-1:0]    r_cnt;
    logic             r_valid;
    logic [WIDTH-1:0] r_dout;
    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_rp_nxt;
    logic [CW-1:0]    w_keep;

    assign full     = r_cnt == FULL;
    assign empty    = !r_valid;
    assign dout     = r_dout;
    assign count    = r_cnt;
    assign w_pop    = pop && r_valid;
    assign w_push   = push && (!full || w_pop);
    assign w_rp_nxt = r_rp + AW'(w_pop);
    assign w_keep   = r_cnt - CW'(w_pop);

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wp] <= din;
    end

    // When the FIFO would drain to zero, the incoming word bypasses the array into the head register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_wp    <= r_wp + AW'(w_push);
            r_rp    <= w_rp_nxt;
            r_cnt   <= w_keep + CW'(w_push);
            r_valid <= (w_keep != '0) || w_push;
            r_dout  <= (w_keep == '0) ? din : r_mem[w_rp_nxt];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && push && full && !w_pop) $error("resp_fifo: push while full");
    end

endmodule

// File: rtl/bram_read_server.sv
// bram_read_server: in-order read client for the stall BRAM with credit flow control,
// so a word captured from the BRAM always has a FIFO slot waiting for it.
module bram_read_server
    import bram_rd_pkg::*;
#(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1,
    parameter int PIPELINED  = 0,
    parameter int RESP_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_deq,
    input  logic [DATA_WIDTH-1:0] bram_dout
);
    localparam int L  = bram_lat(PIPELINED);
    localparam int CW = credit_w(RESP_DEPTH);

    if (RESP_DEPTH < 2 || (RESP_DEPTH & (RESP_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "bram_read_server: RESP_DEPTH must be a power of 2 and >= 2");
    end

    logic [CW-1:0] r_credits;
    logic [L-1:0]  r_vp;
    logic          w_accept;
    logic          w_pop;
    logic          w_empty;
    logic          w_full;
    logic [CW-1:0] w_count;

    assign req_ready  = (r_credits != '0) && !RST;
    assign w_accept   = req_valid && req_ready;
    assign w_pop      = resp_valid && resp_ready;
    assign bram_en    = w_accept;
    assign bram_we    = 1'b0;
    assign bram_addr  = req_addr;
    // The output register only moves on EN or DEQ, so an idle cycle behind a read must DEQ it.
    assign bram_deq   = (PIPELINED != 0) && r_vp[0] && !w_accept;
    assign resp_valid = !w_empty;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_credits <= CW'(RESP_DEPTH);
            r_vp      <= '0;
        end else begin
            r_credits <= r_credits + CW'(w_pop) - CW'(w_accept);
            r_vp      <= L'({r_vp, w_accept});
        end
    end

    resp_fifo #(
        .WIDTH(DATA_WIDTH),
        .DEPTH(RESP_DEPTH)
    ) u_fifo (
        .CLK  (CLK),
        .RST  (RST),
        .push (r_vp[L-1]),
        .din  (bram_dout),
        .pop  (resp_ready),
        .dout (resp_data),
        .empty(w_empty),
        .full (w_full),
        .count(w_count)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (int'(r_credits) + $countones(r_vp) + int'(w_count) == RESP_DEPTH)
                else $error("bram_read_server: credit invariant broken");
            assert (!(w_full && r_credits != '0))
                else $error("bram_read_server: credits left while FIFO full");
        end
    end

endmodule

// File: tb/tb_bram_read_server.sv
// tb_bram_read_server: directed bench driving PIPELINED=0 and PIPELINED=1 instances side by side.
module tb_bram_read_server;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       resp_ready = 1'b0;
    logic [3:0] req_addr = '0;

    logic       rr [2];
    logic       rv [2];
    logic       en [2];
    logic       we [2];
    logic       deq [2];
    logic [7:0] rd [2];
    logic [7:0] dout [2];
    logic [3:0] baddr [2];
    logic [2:0] cred [2];

    logic [7:0] q [2][$];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [7:0] mem [16];
        logic [7:0] r_lat;
        logic [7:0] r_oreg;
        initial for (int i = 0; i < 16; i++) mem[i] = 8'(i * 3);
        // Stall BRAM: read latch loads on EN, output register advances on EN or DEQ.
        always @(posedge clk) begin
            if (en[g]) r_lat <= mem[baddr[g]];
            if (en[g] || deq[g]) r_oreg <= r_lat;
        end
        assign dout[g] = (g != 0) ? r_oreg : r_lat;
        bram_read_server #(
            .ADDR_WIDTH(4),
            .DATA_WIDTH(8),
            .PIPELINED (g),
            .RESP_DEPTH(4)
        ) u_dut (
            .CLK       (clk),
            .RST       (rst),
            .req_valid (req_valid),
            .req_ready (rr[g]),
            .req_addr  (req_addr),
            .resp_valid(rv[g]),
            .resp_ready(resp_ready),
            .resp_data (rd[g]),
            .bram_en   (en[g]),
            .bram_we   (we[g]),
            .bram_addr (baddr[g]),
            .bram_deq  (deq[g]),
            .bram_dout (dout[g])
        );
        assign cred[g] = u_dut.r_credits;
    end

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s [PIPELINED=%0d]: observed %0d expected %0d", tag, k, obs, exp);
        end
    endtask

    task automatic tick();
        logic [7:0] e;
        #1;
        for (int k = 0; k < 2; k++) begin
            if (rv[k] && resp_ready) begin
                chk("resp_expected", k, 32'(q[k].size() != 0), 1);
                if (q[k].size() != 0) begin
                    e = q[k].pop_front();
                    chk("resp_data", k, 32'(rd[k]), 32'(e));
                end
            end
            if (req_valid && rr[k]) q[k].push_back(8'(req_addr) * 8'd3);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [3:0] a);
        logic ok;
        ok = 1'b0;
        req_valid = 1'b1;
        req_addr = a;
        for (int n = 0; n < 20 && !ok; n++) begin
            #1;
            ok = rr[0];
            tick();
        end
        req_valid = 1'b0;
        chk("accept_timeout", 0, 32'(ok), 1);
    endtask

    task automatic drain(input int n);
        req_valid = 1'b0;
        repeat (n) tick();
        for (int k = 0; k < 2; k++) begin
            chk("drain_empty", k, 32'(q[k].size()), 0);
            chk("drain_valid", k, 32'(rv[k]), 0);
            chk("drain_credits", k, 32'(cred[k]), 4);
        end
    endtask

    initial begin
        // Reset: request held high must not reach the BRAM
        req_valid = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_req_ready", k, 32'(rr[k]), 0);
            chk("rst_bram_en", k, 32'(en[k]), 0);
            chk("rst_resp_valid", k, 32'(rv[k]), 0);
            chk("rst_bram_deq", k, 32'(deq[k]), 0);
        end
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("post_rst_req_ready", k, 32'(rr[k]), 1);
            chk("post_rst_resp_valid", k, 32'(rv[k]), 0);
            chk("post_rst_bram_en", k, 32'(en[k]), 0);
            chk("post_rst_bram_deq", k, 32'(deq[k]), 0);
            chk("post_rst_credits", k, 32'(cred[k]), 4);
            chk("bram_we", k, 32'(we[k]), 0);
        end

        // Stream 0..15, one per cycle, first response L edges after the accept edge
        resp_ready = 1'b1;
        for (int a = 0; a < 16; a++) begin
            req_valid = 1'b1;
            req_addr = 4'(a);
            #1;
            for (int k = 0; k < 2; k++) begin
                chk("stream_ready", k, 32'(rr[k]), 1);
                chk("stream_en", k, 32'(en[k]), 1);
                chk("stream_addr", k, 32'(baddr[k]), 32'(a));
                chk("stream_no_deq", k, 32'(deq[k]), 0);
            end
            tick();
            if (a == 0) begin
                chk("lat_first", 0, 32'(rv[0]), 0);
                chk("lat_first", 1, 32'(rv[1]), 0);
            end
            if (a == 1) begin
                chk("lat_second", 0, 32'(rv[0]), 1);
                chk("lat_second", 1, 32'(rv[1]), 0);
            end
            if (a >= 2) begin
                chk("no_bubble", 0, 32'(rv[0]), 1);
                chk("no_bubble", 1, 32'(rv[1]), 1);
            end
        end
        req_valid = 1'b0;
        #1;
        chk("tail_deq", 1, 32'(deq[1]), 1);
        chk("tail_deq", 0, 32'(deq[0]), 0);
        drain(4);

        // Credit stall: 6 requests with consumer stalled, only 4 accepted
        resp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_addr = 4'(5 + i);
            #1;
            chk("credit_accept", 0, 32'(rr[0]), 32'(i < 4));
            chk("credit_accept", 1, 32'(rr[1]), 32'(i < 4));
            tick();
        end
        req_addr = 4'd9;
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            chk("stall_ready", k, 32'(rr[k]), 0);
            chk("stall_valid", k, 32'(rv[k]), 1);
            chk("stall_credits", k, 32'(cred[k]), 0);
        end
        resp_ready = 1'b1;
        issue(4'd9);
        issue(4'd10);
        drain(6);

        // PIPELINED=1 single read then idle: one DEQ cycle right after the accept
        req_valid = 1'b1;
        req_addr = 4'd7;
        #1;
        chk("single_deq_accept", 1, 32'(deq[1]), 0);
        tick();
        req_valid = 1'b0;
        #1;
        chk("single_deq", 1, 32'(deq[1]), 1);
        chk("single_deq", 0, 32'(deq[0]), 0);
        tick();
        #1;
        chk("single_deq_after", 1, 32'(deq[1]), 0);
        tick();
        chk("single_capture", 1, 32'(rv[1]), 1);
        chk("single_capture_data", 1, 32'(rd[1]), 21);
        drain(3);

        // Full FIFO, then pop with accept each cycle: credits hold steady
        resp_ready = 1'b0;
        for (int i = 12; i < 16; i++) issue(4'(i));
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            chk("full_credits", k, 32'(cred[k]), 0);
            chk("full_valid", k, 32'(rv[k]), 1);
        end
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_addr = 4'(i);
            #1;
            for (int k = 0; k < 2; k++) chk("popacc_ready", k, 32'(rr[k]), 32'(i > 0));
            tick();
            for (int k = 0; k < 2; k++) chk("popacc_credits", k, 32'(cred[k]), 1);
        end
        drain(6);

        // Reset with 3 words queued and 1 read in flight
        resp_ready = 1'b0;
        issue(4'd1);
        issue(4'd2);
        issue(4'd3);
        repeat (3) tick();
        issue(4'd4);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("midrst_valid", k, 32'(rv[k]), 0);
            chk("midrst_ready", k, 32'(rr[k]), 0);
            q[k].delete();
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        resp_ready = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rel_credits", k, 32'(cred[k]), 4);
            chk("rel_ready", k, 32'(rr[k]), 1);
        end
        for (int n = 0; n < 4; n++) begin
            tick();
            for (int k = 0; k < 2; k++) chk("no_stale", k, 32'(rv[k]), 0);
        end
        issue(4'd15);
        drain(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
